// File: rtl/fp_pkg.sv
// Shared definitions for the sign-magnitude multiplier chain: widths,
// sign-magnitude <-> two's-complement helpers and the accumulator state type.
package fp_pkg;

    localparam int N1    = 24;
    localparam int N2    = 16;
    localparam int N_RES = 32;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_e;

    // Negative zero maps to 0 because -0 == 0 in two's complement.
    function automatic logic signed [N_RES-1:0] sm2tc_res(input logic [N_RES-1:0] sm);
        logic signed [N_RES-1:0] mag;
        mag = signed'({1'b0, sm[N_RES-2:0]});
        return sm[N_RES-1] ? -mag : mag;
    endfunction

    // The most negative value has no sign-magnitude twin; it clamps to full scale.
    function automatic logic [N_RES-1:0] tc2sm_res(input logic signed [N_RES-1:0] tc);
        logic [N_RES-1:0] mag;
        mag = tc[N_RES-1] ? unsigned'(-tc) : unsigned'(tc);
        if (mag[N_RES-1]) begin
            mag = {1'b0, {(N_RES-1){1'b1}}};
        end
        return {tc[N_RES-1] && (mag != '0), mag[N_RES-2:0]};
    endfunction

endpackage

// File: rtl/sm_to_tc.sv
// Combinational sign-magnitude to two's-complement converter, sign-extended
// to N_TC bits; negative zero converts to 0.
module sm_to_tc #(
    parameter int N_IN = 32,
    parameter int N_TC = 40
) (
    input  logic [N_IN-1:0]        sm_i,
    output logic signed [N_TC-1:0] tc_o
);

    logic signed [N_TC-1:0] mag;

    assign mag  = signed'(N_TC'(sm_i[N_IN-2:0]));
    assign tc_o = sm_i[N_IN-1] ? -mag : mag;

endmodule

// File: rtl/fp_accum.sv
// Frame accumulator for sign-magnitude products: sums FRAME_LEN products, scales,
// saturates and returns the result in sign-magnitude. Define FP_ACCUM_ROUND_EN for round-half-up scaling.
module fp_accum
    import fp_pkg::*;
#(
    parameter int N_IN      = 32,
    parameter int FRAME_LEN = 16,
    parameter int N_ACC     = 40,
    parameter int OUT_SHIFT = 4,
    parameter int N_OUT     = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N_IN-1:0]              in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [N_OUT-1:0]             out_data,
    output logic                         out_sat,
    output logic [$clog2(FRAME_LEN)-1:0] frame_cnt
);

    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam logic [N_ACC:0] MAXM = (N_ACC+1)'((64'd1 << (N_OUT-1)) - 64'd1);
`ifdef FP_ACCUM_ROUND_EN
    localparam logic [N_ACC:0] RND =
        (OUT_SHIFT > 0) ? ((N_ACC+1)'(1) << ((OUT_SHIFT > 0) ? OUT_SHIFT-1 : 0)) : '0;
`endif

    if (FRAME_LEN < 2) begin : g_chk_len
        $error("fp_accum: FRAME_LEN must be at least 2");
    end
    if (N_ACC < N_IN + CNT_W + 1) begin : g_chk_acc
        $error("fp_accum: N_ACC too narrow for a full frame");
    end

    // Returns {sat, sign-magnitude result}; scaling works on the magnitude so it is symmetric about zero.
    function automatic logic [N_OUT:0] scale_sat(input logic signed [N_ACC-1:0] s);
        logic [N_ACC:0]   mag;
        logic [N_ACC:0]   m;
        logic [N_OUT-2:0] mres;
        logic             sat;
        mag = s[N_ACC-1] ? (N_ACC+1)'(unsigned'(-s)) : (N_ACC+1)'(unsigned'(s));
`ifdef FP_ACCUM_ROUND_EN
        mag = mag + RND;
`endif
        m    = mag >> OUT_SHIFT;
        sat  = (m > MAXM);
        mres = sat ? '1 : m[N_OUT-2:0];
        return {sat, s[N_ACC-1] && (mres != '0), mres};
    endfunction

    acc_state_e              state_q, state_d;
    logic signed [N_ACC-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    ov_q, ov_d;
    logic [N_OUT-1:0]        od_q, od_d;
    logic                    os_q, os_d;

    logic signed [N_ACC-1:0] tc;
    logic signed [N_ACC-1:0] sum;
    logic [N_OUT:0]          res;
    logic                    accept;

    sm_to_tc #(
        .N_IN (N_IN),
        .N_TC (N_ACC)
    ) u_sm_to_tc (
        .sm_i (in_data),
        .tc_o (tc)
    );

    assign in_ready  = (state_q == ACCUM);
    assign accept    = in_valid && in_ready;
    assign sum       = acc_q + tc;
    assign res       = scale_sat(sum);
    assign out_valid = ov_q;
    assign out_data  = od_q;
    assign out_sat   = os_q;
    assign frame_cnt = cnt_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ov_d    = ov_q;
        od_d    = od_q;
        os_d    = os_q;
        case (state_q)
            ACCUM: begin
                if (accept) begin
                    if (cnt_q == CNT_W'(FRAME_LEN-1)) begin
                        os_d    = res[N_OUT];
                        od_d    = res[N_OUT-1:0];
                        ov_d    = 1'b1;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = HOLD;
                    end else begin
                        acc_d = sum;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (ov_q && out_ready) begin
                    ov_d    = 1'b0;
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            ov_q    <= 1'b0;
            od_q    <= '0;
            os_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
            os_q    <= os_d;
        end
    end

endmodule

// File: tb/tb_fp_accum.sv
// Bench for fp_accum: fixed frame vectors, backpressure/reset sequences and
// random frames against an integer reference model; a second instance covers saturation.
module tb_fp_accum;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_sat;
    logic [3:0]  frame_cnt;

    logic        in_valid2 = 1'b0;
    logic        in_ready2;
    logic [31:0] in_data2 = '0;
    logic        out_valid2;
    logic        out_ready2 = 1'b0;
    logic [31:0] out_data2;
    logic        out_sat2;
    logic [0:0]  frame_cnt2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fp_accum dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .frame_cnt (frame_cnt)
    );

    fp_accum #(
        .FRAME_LEN (2),
        .OUT_SHIFT (0)
    ) dut2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .in_data   (in_data2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .out_data  (out_data2),
        .out_sat   (out_sat2),
        .frame_cnt (frame_cnt2)
    );

    typedef struct {
        string       name;
        logic [31:0] a;
        int          na;
        logic [31:0] b;
        logic [31:0] exp_d;
        logic        exp_s;
    } frame_vec_t;

    typedef struct {
        string       name;
        logic [31:0] p0;
        logic [31:0] p1;
        logic [31:0] exp_d;
        logic        exp_s;
    } pair_vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: integer sum of signed products, magnitude scaled (and rounded), then clamped.
    function automatic logic [32:0] model(input logic [31:0] w[16]);
        longint sum;
        longint a;
        logic   sat;
        logic [30:0] m;
        sum = 0;
        for (int i = 0; i < 16; i++) begin
            if (w[i][31]) sum = sum - longint'(w[i][30:0]);
            else          sum = sum + longint'(w[i][30:0]);
        end
        a = (sum < 0) ? -sum : sum;
`ifdef FP_ACCUM_ROUND_EN
        a = a + 8;
`endif
        a   = a / 16;
        sat = (a > 64'h7FFF_FFFF);
        m   = sat ? 31'h7FFF_FFFF : 31'(a);
        return {sat, (sum < 0) && (m != 0), m};
    endfunction

    task automatic push(input logic [31:0] w);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 100) chk("push_timeout", 1, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input string tag, input logic [31:0] w[16],
                             input logic [31:0] exp_d, input logic exp_s, input int hold);
        int guard;
        for (int i = 0; i < 16; i++) begin
            push(w[i]);
            if (i == 6) chk({tag, "_cnt7"}, frame_cnt, 7);
        end
        chk({tag, "_latency"}, out_valid, 1);
        chk({tag, "_cnt_wrap"}, frame_cnt, 0);
        guard = 0;
        while (!out_valid && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        for (int c = 0; c < hold; c++) begin
            in_valid = 1'($urandom);
            in_data  = $urandom;
            @(posedge clk); #1;
            chk({tag, "_hold_data"}, out_data, exp_d);
            chk({tag, "_hold_ready"}, in_ready, 0);
            chk({tag, "_hold_cnt"}, frame_cnt, 0);
        end
        in_valid = 1'b0;
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_data"}, out_data, exp_d);
        chk({tag, "_sat"}, out_sat, exp_s);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_drop"}, out_valid, 0);
        chk({tag, "_ready"}, in_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_vec_t  fv[6];
        pair_vec_t   pv[3];
        logic [31:0] w[16];
        logic [32:0] e;

        fv[0] = '{"const16", 32'h0000_0010, 16, 32'h0, 32'h0000_0010, 1'b0};
        fv[1] = '{"mixed", 32'h0000_0064, 8, 32'h8000_0028, 32'h0000_001E, 1'b0};
`ifdef FP_ACCUM_ROUND_EN
        fv[2] = '{"neg24", 32'h8000_0018, 1, 32'h8000_0000, 32'h8000_0002, 1'b0};
        fv[4] = '{"neg15", 32'h8000_000F, 1, 32'h0000_0000, 32'h8000_0001, 1'b0};
`else
        fv[2] = '{"neg24", 32'h8000_0018, 1, 32'h8000_0000, 32'h8000_0001, 1'b0};
        fv[4] = '{"neg15", 32'h8000_000F, 1, 32'h0000_0000, 32'h0000_0000, 1'b0};
`endif
        fv[3] = '{"negzero", 32'h8000_0000, 16, 32'h0, 32'h0000_0000, 1'b0};
        fv[5] = '{"fullscale", 32'h7FFF_FFFF, 16, 32'h0, 32'h7FFF_FFFF, 1'b0};

        pv[0] = '{"sat_pos", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1};
        pv[1] = '{"sat_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1};
        pv[2] = '{"small2", 32'h0000_0005, 32'h8000_0007, 32'h8000_0002, 1'b0};

        #12;
        chk("rst_ready", in_ready, 1);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_sat", out_sat, 0);
        chk("rst_cnt", frame_cnt, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 16; i++) w[i] = (i < fv[v].na) ? fv[v].a : fv[v].b;
            run_frame(fv[v].name, w, fv[v].exp_d, fv[v].exp_s, (v == 0) ? 5 : 0);
        end

        // Next frame starts the cycle after the handshake.
        in_valid = 1'b1;
        in_data  = 32'h0000_0010;
        chk("post_hs_ready", in_ready, 1);
        @(posedge clk); #1;
        chk("post_hs_accept", frame_cnt, 1);
        for (int i = 1; i < 7; i++) push(32'h0000_0010);
        chk("mid_cnt7", frame_cnt, 7);
        rst = 1'b1;
        #1;
        chk("midrst_cnt", frame_cnt, 0);
        chk("midrst_valid", out_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) w[i] = 32'h0000_0010;
        run_frame("after_rst", w, 32'h0000_0010, 1'b0, 0);

        for (int i = 0; i < 16; i++) push(32'h0000_0040);
        chk("hold_rst_pre", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("hold_rst_valid", out_valid, 0);
        chk("hold_rst_ready", in_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int v = 0; v < 3; v++) begin
            in_valid2 = 1'b1;
            in_data2  = pv[v].p0;
            @(posedge clk); #1;
            chk({pv[v].name, "_cnt"}, frame_cnt2, 1);
            in_data2 = pv[v].p1;
            @(posedge clk); #1;
            in_valid2 = 1'b0;
            chk({pv[v].name, "_valid"}, out_valid2, 1);
            chk({pv[v].name, "_data"}, out_data2, pv[v].exp_d);
            chk({pv[v].name, "_sat"}, out_sat2, pv[v].exp_s);
            out_ready2 = 1'b1;
            @(posedge clk); #1;
            out_ready2 = 1'b0;
            chk({pv[v].name, "_drop"}, out_valid2, 0);
        end

        for (int f = 0; f < 30; f++) begin
            for (int i = 0; i < 16; i++) begin
                case ($urandom_range(0, 3))
                    0:       w[i] = $urandom;
                    1:       w[i] = {1'($urandom), 31'($urandom_range(0, 40))};
                    2:       w[i] = {1'($urandom), 31'h7FFF_FFFF - 31'($urandom_range(0, 3))};
                    default: w[i] = {1'($urandom), 31'($urandom_range(0, 100000))};
                endcase
            end
            e = model(w);
            run_frame("rand", w, e[31:0], e[32], $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_accum.md
Name: fp_accum

Overview:
- Downstream consumer of the sign-magnitude fixed-point multiplier.
- Accepts one product per cycle and sums a frame of FRAME_LEN products in a widened two's-complement accumulator.
- Scales each frame sum by a right shift, saturates it and returns it in sign-magnitude format through a valid/ready output port.
- Sits between the multiplier and the frame post-processing logic (the MAC back end).

Parameters:
- N_IN, 32: input width; bit N_IN-1 is the sign, the rest is the magnitude (matches the multiplier result).
- FRAME_LEN, 16: products per frame; must be ≥2.
- N_ACC, 40: accumulator width; must be ≥ N_IN+clog2(FRAME_LEN)+1, so the accumulator never overflows.
- OUT_SHIFT, 4: right shift applied to the magnitude of the frame sum.
- N_OUT, 32: output width; bit N_OUT-1 is the sign, the rest is the magnitude.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  in_data holds a product.
- in_ready  out  1  block accepts the product this cycle.
- in_data  in  N_IN  sign-magnitude product.
- out_valid  out  1  out_data holds a frame result.
- out_ready  in  1  consumer accepts the result.
- out_data  out  N_OUT  sign-magnitude frame result.
- out_sat  out  1  frame result was saturated; qualified by out_valid.
- frame_cnt  out  clog2(FRAME_LEN)  number of products accepted in the current frame.

Behaviour:
- Reset, asynchronous and active-high. Clears state to ACCUM, acc to 0, frame_cnt to 0, out_valid to 0, out_data to 0 and out_sat to 0. in_ready is combinational: 1 in ACCUM, 0 in HOLD.
- Input conversion, combinational. tc = sign ? -mag : +mag, sign-extended to N_ACC. Negative zero (sign=1, mag=0) gives tc=0.
- State ACCUM:
  - A product is accepted when in_valid and in_ready are both 1.
  - On acceptance with frame_cnt < FRAME_LEN-1: acc <= acc+tc and frame_cnt increments.
  - On acceptance with frame_cnt = FRAME_LEN-1: form sum = acc+tc and compute the result below. Then out_data and out_sat are registered, out_valid <= 1, acc <= 0, frame_cnt <= 0 and state <= HOLD.
  - Latency: out_valid rises in the cycle after the last product of the frame is accepted.
  - Throughput: one product per clock inside a frame.
- Result computation:
  - s = sign(sum); m = |sum| >> OUT_SHIFT (magnitude truncation, i.e. toward zero).
  - If m > 2^(N_OUT-1)-1: magnitude = all ones and out_sat = 1. Otherwise magnitude = m and out_sat = 0.
  - If the final magnitude is 0, the sign bit is 0 (no negative zero is ever output).
- State HOLD:
  - in_ready = 0; in_data and in_valid are ignored.
  - out_data and out_sat stay stable while out_valid=1 and out_ready=0.
  - When out_valid and out_ready are both 1: out_valid <= 0 and state <= ACCUM. A new frame can be accepted from the next cycle.
- frame_cnt wraps FRAME_LEN-1 → 0 only at frame completion.
- Reset asserted mid-frame discards the partial sum immediately. Reset in HOLD drops the pending result.
- Accumulator overflow is impossible by the N_ACC constraint; saturation applies only at the output.

Optional Feature:
- FP_ACCUM_ROUND_EN defined: magnitude rounding is round-half-up, m = (|sum| + 2^(OUT_SHIFT-1)) >> OUT_SHIFT, applied before the saturation check. This is symmetric about zero, because the rounding acts on the magnitude. With OUT_SHIFT=0 there is no rounding.
- Not defined: truncation as described in Behaviour.

Decomposition:
- Shared package fp_pkg holds:
  - Width constants for the multiplier chain (N1=24, N2=16, N_RES=32).
  - The sign-magnitude ↔ two's-complement conversion functions.
  - The ACCUM/HOLD state enum.
- Sub-module sm_to_tc: purely combinational sign-magnitude to two's-complement converter with negative-zero handling. It is reusable by other consumers of the multiplier.

Test Plan:
- Defaults, 16 products of 0x00000010 → out_data=0x00000010, out_sat=0, out_valid rises 1 cycle after the 16th acceptance.
- 8 products of +100 (0x00000064) and 8 products of -40 (0x80000028) → out_data=0x0000001E.
- 16 products of -24/16 each (sum -24, e.g. one 0x80000018 and fifteen 0x80000000):
  - Without the macro → out_data=0x80000001.
  - With FP_ACCUM_ROUND_EN → out_data=0x80000002.
- FRAME_LEN=2, OUT_SHIFT=0, two products of 0x7FFFFFFF → out_data=0x7FFFFFFF, out_sat=1. The same test with two products of 0xFFFFFFFF → out_data=0xFFFFFFFF, out_sat=1.
- Backpressure: out_ready held 0 for 5 cycles after out_valid rises → out_data stable, in_ready=0, in_valid pulses ignored. After the handshake, the next frame's first product is accepted one cycle later.
- rst pulsed after 7 accepted products → frame_cnt=0, out_valid=0. The following 16 products of 0x00000010 → out_data=0x00000010 (no carry-over from the discarded partial frame).
